// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle between the MEM stage pipeline registers, the SRAM controller and the external SRAM pins.
interface mem_stage_sram_ctrl_if #(
  parameter int unsigned SRAM_AW = 18
);
  // Pipeline side
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  // SRAM side
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic [15:0]        sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;
  logic               sram_oe_n;

  // Environment view: drives requests and SRAM read data, observes everything else
  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  // Controller view
  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage data-memory sequencer: splits each 32-bit load/store into two 16-bit
// SRAM accesses (low half, then high half), each held WAIT_CYCLES clocks, and
// freezes the pipeline through `ready` while the access is in flight.
module mem_stage_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         read_data_q, read_data_d;

  logic                req;
  logic [31:0]         offset;
  logic                cnt_last;
  logic                busy;
  logic                unused_offset_bits;

  logic [SRAM_AW-1:0]  sram_addr_c;
  logic [15:0]         sram_dq_out_c;
  logic                sram_dq_oe_c;
  logic                sram_we_n_c;
  logic                sram_oe_n_c;
  logic                ready_c;

  assign req      = bus.wr_en | bus.rd_en;
  // Byte offset from the SRAM window base; wraps modulo 2^32, no range check
  assign offset   = bus.address - 32'(ADDR_BASE);
  assign cnt_last = (cnt_q == CNT_LAST);
  assign busy     = (state_q == LO) || (state_q == HI);

  // Byte-lane bits and word bits beyond the SRAM depth are intentionally dropped
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

  // Next-state sequencing: IDLE latches the request, LO/HI each run WAIT_CYCLES, DONE lasts one cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          // A simultaneous read and write request is performed as a write
          op_wr_d = bus.wr_en;
          word_d  = offset[SRAM_AW:2];
          wdata_d = bus.write_data;
          cnt_d   = '0;
          state_d = LO;
        end
      end

      LO: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = HI;
          if (!op_wr_q) begin
            read_data_d = {read_data_q[31:16], bus.sram_dq_in};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HI: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!op_wr_q) begin
            read_data_d = {bus.sram_dq_in, read_data_q[15:0]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Request inputs are still asserted here; they must not start a new access
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pin decode from registered state only; everything inactive outside LO/HI
  always_comb begin
    sram_addr_c   = '0;
    sram_dq_out_c = '0;
    sram_dq_oe_c  = 1'b0;
    sram_we_n_c   = 1'b1;
    sram_oe_n_c   = 1'b1;

    if (busy) begin
      sram_addr_c = {word_q, (state_q == HI)};
      if (op_wr_q) begin
        sram_dq_out_c = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
        sram_dq_oe_c  = 1'b1;
        sram_we_n_c   = 1'b0;
      end else begin
        sram_oe_n_c   = 1'b0;
      end
    end
  end

  // Pipeline freeze: low for the request cycle in IDLE and all of LO/HI; forced high in reset
  always_comb begin
    ready_c = 1'b1;
    if (!rst) begin
      if (((state_q == IDLE) && req) || busy) begin
        ready_c = 1'b0;
      end
    end
  end

  assign bus.sram_addr   = sram_addr_c;
  assign bus.sram_dq_out = sram_dq_out_c;
  assign bus.sram_dq_oe  = sram_dq_oe_c;
  assign bus.sram_we_n   = sram_we_n_c;
  assign bus.sram_oe_n   = sram_oe_n_c;
  assign bus.ready       = ready_c;
  assign bus.read_data   = read_data_q;

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Sequences the data-memory access for the MEM stage. Inputs come from the EXE/MEM pipeline register outputs: MEM_R_EN, MEM_W_EN, ALU_Result (address) and ST_val (store data).
- Splits each 32-bit access into two 16-bit accesses to an external SRAM.
- Holds `ready` low while an access is in flight; the hazard/pipeline logic uses `ready` to freeze all pipeline registers.
- Returns the assembled 32-bit load word to the MEM/WB register.

Parameters:
- WAIT_CYCLES, 1, cycles each 16-bit half access is held on the SRAM pins (legal range 1..15).
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM address width in 16-bit halfwords.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  store request (MEM_W_EN).
- rd_en  input  1  load request (MEM_R_EN).
- address  input  32  byte address (ALU_Result).
- write_data  input  32  store data (ST_val).
- read_data  output  32  assembled load word.
- ready  output  1  1 = no access pending; 0 = freeze pipeline.
- sram_addr  output  SRAM_AW  SRAM halfword address.
- sram_dq_out  output  16  write data to SRAM.
- sram_dq_in  input  16  read data from SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the SRAM bus.
- sram_we_n  output  1  SRAM write enable, active-low.
- sram_oe_n  output  1  SRAM output enable, active-low.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-high reset, rst.
- Reset values: state=IDLE, wait counter=0, latched address/data/op=0, read_data=0, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
  - ready is 1 while rst is asserted (IDLE with no request counts as idle).
  - Reset mid-access aborts immediately; no further SRAM cycles are issued.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If wr_en|rd_en: latch the operation, word index, and write_data; go to LO with counter=0.
  - If wr_en and rd_en are both 1: treat as a write.
- LO:
  - Counter increments each cycle.
  - At counter==WAIT_CYCLES-1: go to HI, counter=0.
  - For a read, capture sram_dq_in into read_data[15:0] on that same last edge.
- HI:
  - Same counter behaviour as LO.
  - At counter==WAIT_CYCLES-1: capture read_data[31:16] (read only), go to DONE.
- DONE: one cycle, then IDLE unconditionally. The inputs are still asserted during this cycle and must not start a new access.
- ready is combinational:
  - 0 when (state==IDLE and (wr_en|rd_en)), or state==LO, or state==HI.
  - 1 otherwise.
  - Stall per access is exactly 2*WAIT_CYCLES+1 cycles of ready=0. ready=1 in DONE, and the pipeline advances at the end of DONE.
- Address mapping:
  - word = (address - ADDR_BASE) >> 2, modulo 2^32, no range check.
  - sram_addr = {word[SRAM_AW-2:0], half}; half=0 in LO, 1 in HI.
  - sram_addr=0 in IDLE/DONE.
- Write data and pin control:
  - Write: sram_dq_out = write_data[15:0] in LO, write_data[31:16] in HI, 0 otherwise.
  - Write: sram_dq_oe=1 and sram_we_n=0 in LO/HI.
  - Read: sram_oe_n=0 in LO/HI, and sram_dq_oe=0.
  - All SRAM control signals are inactive in IDLE/DONE. SRAM pin values are decoded from registered state only.
- read_data:
  - Holds its value until the next read overwrites it; writes never modify it.
  - read_data is valid in DONE and afterwards.
- Back-to-back requests: the next access starts from IDLE, so there is at least one IDLE cycle between accesses. In that IDLE cycle ready=0 if a request is present.

Test Plan:
- WAIT_CYCLES=1, store 0x12345678 at address 1024:
  - ready=0 for 3 cycles.
  - SRAM write sequence: addr 0 data 0x5678, then addr 1 data 0x1234, sram_we_n low 2 cycles.
  - ready=1 in DONE.
- Load from 1024 after the store, SRAM model returns stored halves -> read_data=0x12345678 in DONE; sram_oe_n low 2 cycles; sram_dq_oe stays 0.
- Store 0xCAFEBABE at 1028 -> SRAM halfword addresses 2 and 3, data 0xBABE then 0xCAFE; load at 1028 returns 0xCAFEBABE.
- WAIT_CYCLES=3, load -> ready=0 for exactly 7 cycles; each SRAM address is held 3 cycles.
- wr_en=rd_en=1, write_data=0xA5A5_5A5A -> performed as a write; read_data unchanged from its prior value.
- Assert rst during HI of a store -> sram_we_n=1, sram_dq_oe=0, ready=1, read_data=0 immediately (asynchronous), state=IDLE; the next load after release completes normally.
